// File: rtl/zb_router_pkg.sv
// zb_router_pkg: shared defaults, types and helpers for the multi-channel
// nibble buffer (zb_chan_fifo_router).
//   DEF_DATA_W / DEF_NUM_CH / DEF_DEPTH : default parameter values
//   rd_mode_e                           : read-side arbitration mode
//   nibble_t                            : one O-QPSK symbol nibble
//   wrapInc()                           : channel index increment with wrap
package zb_router_pkg;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DEPTH  = 8;

    typedef enum logic {RD_SEL = 1'b0, RD_RR = 1'b1} rd_mode_e;

    typedef logic [DEF_DATA_W-1:0] nibble_t;

    function automatic int wrapInc(input int ch, input int n);
        return (ch + 1 >= n) ? 0 : ch + 1;
    endfunction
endpackage

// File: rtl/zb_chan_fifo_router_if.sv
// zb_chan_fifo_router_if: handshake/bus bundle of the channel FIFO router.
//   slave  modport : router side (inputs in*, outputs out*)
//   master modport : controller/datapath side driving the router
// Optional macro ZB_ROUTER_LEVEL_EN adds the per-channel fill level bus.
interface zb_chan_fifo_router_if #(
    parameter int DATA_W = zb_router_pkg::DEF_DATA_W,
    parameter int NUM_CH = zb_router_pkg::DEF_NUM_CH,
    parameter int DEPTH  = zb_router_pkg::DEF_DEPTH
);
    import zb_router_pkg::*;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              inClear;
    logic [DATA_W-1:0] inData;
    logic              inWriteEnable;
    logic [CH_W-1:0]   inWrSel;
    logic              inReadEnable;
    logic [CH_W-1:0]   inRdSel;
    logic              inRdMode;
    logic [DATA_W-1:0] outData;
    logic              outValid;
    logic [CH_W-1:0]   outChannel;
    logic [NUM_CH-1:0] outFull;
    logic [NUM_CH-1:0] outEmpty;
    logic              outOverflow;
    logic              outUnderflow;
`ifdef ZB_ROUTER_LEVEL_EN
    logic [NUM_CH*(ADDR_W+1)-1:0] outLevel;
`endif

    modport slave (
        input  inClear, inData, inWriteEnable, inWrSel, inReadEnable, inRdSel, inRdMode,
        output outData, outValid, outChannel, outFull, outEmpty, outOverflow, outUnderflow
`ifdef ZB_ROUTER_LEVEL_EN
        , output outLevel
`endif
    );

    modport master (
        output inClear, inData, inWriteEnable, inWrSel, inReadEnable, inRdSel, inRdMode,
        input  outData, outValid, outChannel, outFull, outEmpty, outOverflow, outUnderflow
`ifdef ZB_ROUTER_LEVEL_EN
        , input outLevel
`endif
    );
endinterface

// File: rtl/zb_chan_fifo.sv
// zb_chan_fifo: single-channel circular FIFO.
//   inClock/inReset : clock, async active-high reset
//   clear           : synchronous pointer flush (memory is left untouched)
//   push/pushData   : write one word (caller guarantees !full)
//   pop/headData    : headData is the current head, pop advances past it
//   full/empty      : combinational from the registered pointers
//   level           : wrPtr-rdPtr (only with ZB_ROUTER_LEVEL_EN)
module zb_chan_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              inClock,
    input  logic              inReset,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic [DATA_W-1:0] headData,
    output logic              full,
    output logic              empty
`ifdef ZB_ROUTER_LEVEL_EN
    , output logic [ADDR_W:0] level
`endif
);
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [ADDR_W:0]   wrPtr;
    logic [ADDR_W:0]   rdPtr;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge inClock) begin
        if (push) mem[wrPtr[ADDR_W-1:0]] <= pushData;
    end

    assign headData = mem[rdPtr[ADDR_W-1:0]];
    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[ADDR_W] != rdPtr[ADDR_W]) &&
                      (wrPtr[ADDR_W-1:0] == rdPtr[ADDR_W-1:0]);
`ifdef ZB_ROUTER_LEVEL_EN
    assign level = wrPtr - rdPtr;
`endif
endmodule

// File: rtl/zb_chan_fifo_router.sv
// zb_chan_fifo_router: NUM_CH independent nibble FIFOs behind a write demux
// and a read mux driven either by an explicit select or a round-robin arbiter.
//   inClock/inReset : clock, async active-high reset
//   bus (slave)     : write port (inData/inWriteEnable/inWrSel), read request
//                     (inReadEnable/inRdSel/inRdMode), flush (inClear),
//                     registered read result (outData/outValid/outChannel),
//                     per-channel outFull/outEmpty, sticky outOverflow/outUnderflow
// Optional macro ZB_ROUTER_LEVEL_EN exposes per-channel fill level on bus.outLevel.
module zb_chan_fifo_router
    import zb_router_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int CH_W   = $clog2(NUM_CH),
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  inClock,
    input  logic                  inReset,
    zb_chan_fifo_router_if.slave  bus
);
    logic [NUM_CH-1:0] fullVec, emptyVec, pushVec, popVec;
    logic [DATA_W-1:0] headData [NUM_CH];

    logic [CH_W-1:0]   rrPtr, rrCh, rdCh;
    logic              rrFound, rdAccept, rdReject, wrAccept, wrReject;
    int                idx;
    rd_mode_e          rdMode;

    logic [DATA_W-1:0] dataReg;
    logic              validReg, overflowReg, underflowReg;
    logic [CH_W-1:0]   chanReg;

    assign rdMode = rd_mode_e'(bus.inRdMode);

    // Full is sampled before the edge, so a same-cycle pop never rescues a write.
    assign wrReject = bus.inWriteEnable && fullVec[bus.inWrSel];
    assign wrAccept = bus.inWriteEnable && !fullVec[bus.inWrSel] && !bus.inClear;

    // Round-robin search: first non-empty channel from rrPtr upward, wrapping.
    always_comb begin
        rrFound = 1'b0;
        rrCh    = '0;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rrPtr) + i) % NUM_CH;
            if (!rrFound && !emptyVec[idx]) begin
                rrFound = 1'b1;
                rrCh    = CH_W'(idx);
            end
        end
    end

    always_comb begin
        rdCh     = bus.inRdSel;
        rdAccept = 1'b0;
        rdReject = 1'b0;
        if (rdMode == RD_RR) begin
            rdCh     = rrCh;
            rdAccept = bus.inReadEnable && rrFound;
        end else begin
            rdAccept = bus.inReadEnable && !emptyVec[bus.inRdSel];
            rdReject = bus.inReadEnable && emptyVec[bus.inRdSel];
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gChan
        assign pushVec[gi] = wrAccept && (bus.inWrSel == CH_W'(gi));
        assign popVec[gi]  = rdAccept && !bus.inClear && (rdCh == CH_W'(gi));

        zb_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) uFifo (
            .inClock  (inClock),
            .inReset  (inReset),
            .clear    (bus.inClear),
            .push     (pushVec[gi]),
            .pushData (bus.inData),
            .pop      (popVec[gi]),
            .headData (headData[gi]),
            .full     (fullVec[gi]),
            .empty    (emptyVec[gi])
`ifdef ZB_ROUTER_LEVEL_EN
            , .level  (bus.outLevel[gi*(ADDR_W+1) +: (ADDR_W+1)])
`endif
        );
    end

    // Output register; outData/outChannel hold when no word is popped.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            dataReg      <= '0;
            chanReg      <= '0;
            validReg     <= 1'b0;
            overflowReg  <= 1'b0;
            underflowReg <= 1'b0;
            rrPtr        <= '0;
        end else if (bus.inClear) begin
            validReg     <= 1'b0;
            overflowReg  <= 1'b0;
            underflowReg <= 1'b0;
            rrPtr        <= '0;
        end else begin
            validReg <= rdAccept;
            if (rdAccept) begin
                dataReg <= headData[rdCh];
                chanReg <= rdCh;
            end
            if (rdAccept && rdMode == RD_RR) rrPtr <= CH_W'(wrapInc(int'(rrCh), NUM_CH));
            if (wrReject) overflowReg  <= 1'b1;
            if (rdReject) underflowReg <= 1'b1;
        end
    end

    assign bus.outData      = dataReg;
    assign bus.outValid     = validReg;
    assign bus.outChannel   = chanReg;
    assign bus.outFull      = fullVec;
    assign bus.outEmpty     = emptyVec;
    assign bus.outOverflow  = overflowReg;
    assign bus.outUnderflow = underflowReg;
endmodule

// File: tb/tb_zb_chan_fifo_router.sv
// tb_zb_chan_fifo_router: randomized + directed bench for zb_chan_fifo_router.
// A queue-per-channel reference model predicts each clock edge's outcome; the
// driver pushes the prediction, an independent monitor pops and compares.
// Build with ZB_ROUTER_LEVEL_EN to also check outLevel.
module tb_zb_chan_fifo_router;
    import zb_router_pkg::*;

    localparam int DATA_W = 4;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int CH_W   = 2;
    localparam int LV_W   = 4;

    typedef struct packed {
        logic                   valid;
        logic [DATA_W-1:0]      data;
        logic [CH_W-1:0]        ch;
        logic                   ovf;
        logic                   unf;
        logic [NUM_CH-1:0]      full;
        logic [NUM_CH-1:0]      empty;
        logic [NUM_CH*LV_W-1:0] level;
    } exp_t;

    logic inClock = 1'b0;
    logic inReset = 1'b1;
    always #5 inClock = ~inClock;

    zb_chan_fifo_router_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) bus ();

    zb_chan_fifo_router #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .inClock (inClock),
        .inReset (inReset),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    exp_t    expQ [$];
    nibble_t mq [NUM_CH][$];
    int      rr = 0;
    bit      ovf = 0, unf = 0;
    nibble_t lastData = '0;
    int      lastCh = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
        rr = 0; ovf = 0; unf = 0; lastData = '0; lastCh = 0;
    endtask

    // Drive one cycle of stimulus and queue the predicted post-edge state.
    task automatic cycle(input bit we, input int ws, input nibble_t wd,
                         input bit re, input int rs, input bit mode, input bit clr);
        exp_t e;
        bit   doRead, wOk;
        int   rch, c;
        @(negedge inClock);
        bus.inWriteEnable = we;
        bus.inWrSel       = CH_W'(ws);
        bus.inData        = wd;
        bus.inReadEnable  = re;
        bus.inRdSel       = CH_W'(rs);
        bus.inRdMode      = mode;
        bus.inClear       = clr;
        e = '0;
        doRead = 0; rch = 0;
        if (clr) begin
            for (int k = 0; k < NUM_CH; k++) mq[k].delete();
            rr = 0; ovf = 0; unf = 0;
        end else begin
            if (re) begin
                if (!mode) begin
                    if (mq[rs].size() > 0) begin doRead = 1; rch = rs; end
                    else unf = 1;
                end else begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        c = (rr + k) % NUM_CH;
                        if (!doRead && mq[c].size() > 0) begin doRead = 1; rch = c; end
                    end
                end
            end
            wOk = we && (mq[ws].size() < DEPTH);
            if (we && !wOk) ovf = 1;
            if (doRead) begin
                lastData = mq[rch].pop_front();
                lastCh   = rch;
                if (mode) rr = (rch + 1) % NUM_CH;
            end
            if (wOk) mq[ws].push_back(wd);
        end
        e.valid = doRead;
        e.data  = lastData;
        e.ch    = CH_W'(lastCh);
        e.ovf   = ovf;
        e.unf   = unf;
        for (int k = 0; k < NUM_CH; k++) begin
            e.full[k]  = (mq[k].size() == DEPTH);
            e.empty[k] = (mq[k].size() == 0);
            e.level[k*LV_W +: LV_W] = LV_W'(mq[k].size());
        end
        expQ.push_back(e);
    endtask

    task automatic idle();
        cycle(0, 0, 4'h0, 0, 0, 0, 0);
    endtask

    // Monitor: consumes one prediction per clock edge, decoupled from the driver.
    initial begin
        exp_t e;
        forever begin
            @(posedge inClock);
            #2;
            if (!inReset && expQ.size() > 0) begin
                e = expQ.pop_front();
                check("outValid", 32'(bus.outValid), 32'(e.valid));
                check("outData", 32'(bus.outData), 32'(e.data));
                check("outChannel", 32'(bus.outChannel), 32'(e.ch));
                check("outOverflow", 32'(bus.outOverflow), 32'(e.ovf));
                check("outUnderflow", 32'(bus.outUnderflow), 32'(e.unf));
                check("outFull", 32'(bus.outFull), 32'(e.full));
                check("outEmpty", 32'(bus.outEmpty), 32'(e.empty));
`ifdef ZB_ROUTER_LEVEL_EN
                check("outLevel", 32'(bus.outLevel), 32'(e.level));
`endif
            end else if (!inReset && bus.outValid) begin
                check("unexpectedValid", 32'(bus.outValid), 32'd0);
            end
        end
    end

    initial begin
        bus.inWriteEnable = 0; bus.inWrSel = '0; bus.inData = '0;
        bus.inReadEnable = 0;  bus.inRdSel = '0; bus.inRdMode = 0; bus.inClear = 0;
        modelReset();
        repeat (2) @(negedge inClock);
        check("rstEmpty", 32'(bus.outEmpty), 32'hF);
        check("rstFull", 32'(bus.outFull), 32'h0);
        check("rstValid", 32'(bus.outValid), 32'h0);
        check("rstData", 32'(bus.outData), 32'h0);
        check("rstChannel", 32'(bus.outChannel), 32'h0);
        check("rstOverflow", 32'(bus.outOverflow), 32'h0);
        check("rstUnderflow", 32'(bus.outUnderflow), 32'h0);
        inReset = 0;
        idle();

        // Select mode: three words through ch2, then an underflowing read.
        for (int i = 1; i <= 3; i++) cycle(1, 2, nibble_t'(i), 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 4'h0, 1, 2, 0, 0);
        idle();

        // Fill ch0, overflow with 0xF, drain.
        cycle(0, 0, 4'h0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, nibble_t'(i + 3), 0, 0, 0, 0);
        cycle(1, 0, 4'hF, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 4'h0, 1, 0, 0, 0);

        // Round-robin order across ch0 and ch3.
        cycle(0, 0, 4'h0, 0, 0, 0, 1);
        cycle(1, 0, 4'hA, 0, 0, 0, 0);
        cycle(1, 0, 4'hB, 0, 0, 0, 0);
        cycle(1, 3, 4'hC, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 4'h0, 1, 0, 1, 0);

        // Same-cycle write and read on ch1.
        cycle(0, 0, 4'h0, 0, 0, 0, 1);
        cycle(1, 1, 4'h5, 0, 0, 0, 0);
        cycle(1, 1, 4'h6, 1, 1, 0, 0);
        cycle(0, 0, 4'h0, 1, 1, 0, 0);

        // Clear with queued data and both sticky flags set; clear-cycle write is lost.
        for (int i = 0; i < DEPTH + 1; i++) cycle(1, 2, nibble_t'(i), 0, 0, 0, 0);
        cycle(0, 0, 4'h0, 1, 3, 0, 0);
        cycle(1, 1, 4'h9, 1, 2, 0, 1);
        idle();

        // Five writes to ch3, a read, then reset mid-stream.
        for (int i = 0; i < 5; i++) cycle(1, 3, nibble_t'(i + 7), 0, 0, 0, 0);
        cycle(0, 0, 4'h0, 1, 3, 0, 0);
        @(posedge inClock);
        #3;
        inReset = 1;
        bus.inWriteEnable = 0; bus.inReadEnable = 0;
        #1;
        check("midRstValid", 32'(bus.outValid), 32'h0);
        check("midRstEmpty", 32'(bus.outEmpty), 32'hF);
        check("midRstData", 32'(bus.outData), 32'h0);
`ifdef ZB_ROUTER_LEVEL_EN
        check("midRstLevel", 32'(bus.outLevel), 32'h0);
`endif
        modelReset();
        @(negedge inClock);
        @(negedge inClock);
        inReset = 0;

        // Randomized traffic, write-heavy then read-heavy phases.
        for (int n = 0; n < 2000; n++) begin
            int wp;
            wp = (n < 1000) ? 70 : 35;
            cycle($urandom_range(0, 99) < wp, $urandom_range(0, NUM_CH - 1),
                  nibble_t'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < (100 - wp), $urandom_range(0, NUM_CH - 1),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
        end
        idle();

        // Bounded wait for the monitor to consume every prediction.
        for (int t = 0; t < 20 && expQ.size() > 0; t++) @(negedge inClock);
        if (expQ.size() > 0) check("drainTimeout", 32'(expQ.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
